wait_state_memory: RTL

- Parametrised successor to the fixed 16-bit processor data/instruction memory.
- Word-addressed synchronous RAM behind a request/ready handshake, with a programmable wait-state count.
- Adds address-range and request-conflict error flags and a busy indication.
- Sits between the processor core and the bench; the bench dumps `memData` hierarchically after the run.

---
 rtl/wait_state_memory.sv | 109 ++++++++++
 1 files changed

// File: rtl/wait_state_memory.sv
// Word-addressed synchronous RAM behind a request/ready handshake with programmable wait states.
// Flags out-of-range addresses and simultaneous read/write requests; all outputs are registered.
module wait_state_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  readMEM,
  input  logic                  writeMEM,
  input  logic [ADDR_WIDTH-1:0] addrBus,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  readyMem,
  output logic                  busy,
  output logic                  errAddr,
  output logic                  errReq
);

  // state | meaning
  // IDLE  | waiting for a single read or write request
  // WAIT  | wait counter running; access performed when it reaches zero
  // DONE  | readyMem cycle; returns to IDLE unconditionally
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] memData [0:DEPTH-1];

  state_t                state, nextState;
  logic [7:0]            waitCnt;
  logic [ADDR_WIDTH-1:0] addrLat;
  logic [DATA_WIDTH-1:0] dataLat;
  logic                  opWrite;
  logic                  inRange;
  logic                  singleReq;
  logic                  accessNow;

  // Full-width compare: addresses beyond DEPTH never alias onto real words.
  assign inRange   = ({1'b0, addrLat} < DEPTH_L);
  assign singleReq = readMEM ^ writeMEM;
  assign accessNow = (state == WAIT) && (waitCnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (singleReq) nextState = WAIT;
      WAIT:    if (waitCnt == 8'd0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt  <= '0;
      addrLat  <= '0;
      dataLat  <= '0;
      opWrite  <= 1'b0;
      dataOut  <= '0;
      readyMem <= 1'b0;
      busy     <= 1'b0;
      errAddr  <= 1'b0;
      errReq   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) memData[i] <= '0;
    end else begin
      readyMem <= 1'b0;
      errAddr  <= 1'b0;
      errReq   <= 1'b0;
      case (state)
        IDLE: begin
          if (readMEM && writeMEM) begin
            errReq <= 1'b1;
          end else if (singleReq) begin
            addrLat <= addrBus;
            dataLat <= dataIn;
            opWrite <= writeMEM;
            waitCnt <= 8'(WAIT_CYCLES);
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (!accessNow) begin
            waitCnt <= waitCnt - 8'd1;
          end else begin
            readyMem <= 1'b1;
            errAddr  <= !inRange;
            if (opWrite) begin
              if (inRange) memData[addrLat[IDXW-1:0]] <= dataLat;
            end else begin
              dataOut <= inRange ? memData[addrLat[IDXW-1:0]] : '0;
            end
          end
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
